// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
// Handshake and operand/result bundle for the bit-serial subtractor.
//   start      : request to begin an operation (master -> slave)
//   x, y       : minuend / subtrahend, [0:WIDTH-1], index 0 = MSB
//   borrow_in  : borrow into the LSB
//   busy       : operation in progress (slave -> master)
//   done       : one-cycle pulse, results valid
//   diff       : difference, [0:WIDTH-1], index 0 = MSB
//   borrow_out : borrow out of the MSB
//   overflow   : two's-complement overflow of the difference
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [0:WIDTH-1] x;
    logic [0:WIDTH-1] y;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [0:WIDTH-1] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, x, y, borrow_in,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, x, y, borrow_in,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Computes x - y - borrow_in one bit per clock (LSB first) with a single
// full-subtractor cell. Operands are captured on start in IDLE; results are
// published together on the MSB edge and held until the next accepted start.
//   clk   : rising-edge system clock
//   reset : asynchronous, active-high
//   bus   : serial_subtractor_if slave modport (start/x/y/borrow_in in,
//           busy/done/diff/borrow_out/overflow out)
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input logic                clk,
    input logic                reset,
    serial_subtractor_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [0:WIDTH-1] a_q;          // minuend, shifts toward index WIDTH-1
    logic [0:WIDTH-1] b_q;          // subtrahend, same
    logic [0:WIDTH-1] sreg_q;       // difference bits filled from the MSB side
    logic [0:WIDTH-1] diff_q;       // published difference
    logic [CNT_W-1:0] cnt_q;
    logic             br_q;
    logic             busy_q;
    logic             done_q;
    logic             borrow_out_q;
    logic             overflow_q;

    logic             d_bit_d;
    logic             br_d;
    logic             last_bit;

    // Full-subtractor cell on the current LSB-side bits.
    always_comb begin
        d_bit_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ br_q;
        br_d     = (~a_q[WIDTH-1] & b_q[WIDTH-1]) |
                   (~(a_q[WIDTH-1] ^ b_q[WIDTH-1]) & br_q);
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sreg_q       <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            br_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.x;
                        b_q     <= bus.y;
                        br_q    <= bus.borrow_in;
                        cnt_q   <= '0;
                        sreg_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end

                SHIFT: begin
                    a_q    <= {1'b0, a_q[0:WIDTH-2]};
                    b_q    <= {1'b0, b_q[0:WIDTH-2]};
                    sreg_q <= {d_bit_d, sreg_q[0:WIDTH-2]};
                    br_q   <= br_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        // Results become visible only here, all at once.
                        diff_q       <= {d_bit_d, sreg_q[0:WIDTH-2]};
                        borrow_out_q <= br_d;
                        // Borrow into the MSB cell XOR borrow out of it.
                        overflow_q   <= br_q ^ br_d;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= DONE;
                    end
                end

                DONE: begin
                    // start is deliberately ignored here.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Scoreboard bench: stimulus pushes the arithmetic expectation for each
// accepted operation; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bo;
        logic         ov;
    } exp_t;

    logic clk;
    logic reset;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int x, input int y, input int bin);
        exp_t e;
        int   r;
        int   sx;
        int   sy;
        int   sr;
        r  = x - y - bin;
        sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
        sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
        sr = sx - sy - bin;
        e.diff = r[W-1:0];
        e.bo   = (r < 0);
        e.ov   = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("diff",       32'(bus.diff),       32'(e.diff));
                check("borrow_out", 32'(bus.borrow_out), 32'(e.bo));
                check("overflow",   32'(bus.overflow),   32'(e.ov));
                check("busy_in_done", 32'(bus.busy),     32'd0);
            end
        end
    end

    // Issue one operation from a negedge and follow its busy/done timeline.
    task automatic run_op(input int x, input int y, input int bin);
        bus.x         = W'(x);
        bus.y         = W'(y);
        bus.borrow_in = bin[0];
        bus.start     = 1'b1;
        exp_q.push_back(model(x, y, bin));
        for (int i = 1; i <= W + 1; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            // Scramble operands after capture; must not matter.
            bus.x     = W'($urandom);
            bus.y     = W'($urandom);
            if (i <= W) begin
                check("busy_shift", 32'(bus.busy), 32'd1);
                check("done_shift", 32'(bus.done), 32'd0);
            end else begin
                check("done_pulse", 32'(bus.done), 32'd1);
            end
        end
        @(negedge clk);
        check("done_cleared", 32'(bus.done), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 32'(bus.busy),       32'd0);
        check({tag, "_done"}, 32'(bus.done),       32'd0);
        check({tag, "_diff"}, 32'(bus.diff),       32'd0);
        check({tag, "_bo"},   32'(bus.borrow_out), 32'd0);
        check({tag, "_ov"},   32'(bus.overflow),   32'd0);
    endtask

    initial begin
        int done_before;
        bus.start     = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.borrow_in = 1'b0;
        reset         = 1'b0;

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1 check_cleared("reset_async");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors.
        run_op(4'b0110, 4'b0011, 0);
        run_op(4'b0011, 4'b0110, 0);
        run_op(4'b0000, 4'b0000, 1);
        run_op(4'b1000, 4'b0001, 0);
        run_op(4'b0111, 4'b1000, 0);

        // Results held in IDLE with start low.
        repeat (3) @(negedge clk);
        check("hold_diff", 32'(bus.diff),       32'hF);
        check("hold_bo",   32'(bus.borrow_out), 32'd1);

        // Reset with nonzero outputs clears them immediately.
        #1 reset = 1'b1;
        #1 check_cleared("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // start while busy / in DONE is ignored, not queued.
        done_before   = n_done;
        bus.x         = 4'b0101;
        bus.y         = 4'b0001;
        bus.borrow_in = 1'b0;
        bus.start     = 1'b1;
        exp_q.push_back(model(4'b0101, 4'b0001, 0));
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = 4'b1111;
        bus.y     = 4'b1111;
        for (int i = 3; i <= W + 1; i++) begin
            @(negedge clk);
            bus.x = W'($urandom);
            if (i <= W) check("busy_ignored_start", 32'(bus.busy), 32'd1);
            else        check("done_ignored_start", 32'(bus.done), 32'd1);
        end
        bus.start = 1'b0;
        repeat (W + 3) @(negedge clk);
        check("single_done", 32'(n_done - done_before), 32'd1);
        check("idle_after_ignore", 32'(bus.busy), 32'd0);

        // Reset during the second SHIFT cycle aborts the operation.
        done_before   = n_done;
        bus.x         = 4'b1100;
        bus.y         = 4'b0101;
        bus.borrow_in = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_cleared("reset_abort");
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 2) @(negedge clk);
        check("no_done_after_abort", 32'(n_done - done_before), 32'd0);
        check_cleared("post_abort");
        run_op(4'b1010, 4'b0011, 0);

        // Randomized operations.
        for (int k = 0; k < 40; k++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
